axi_id_remap_table: RTL and testbench

AXI_ID_REMAP_TABLE -- requirements
Module: axi_id_remap_table

---
 rtl/axi_id_remap_pkg.sv | 18 +
 rtl/axi_id_remap_lzc.sv | 22 ++
 rtl/axi_id_remap_table.sv | 162 ++++++++++++++++
 tb/tb_axi_id_remap_table.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_id_remap_pkg.sv
// Shared types for the AXI ID remap table: slot entry layout and counter sizing.
package axi_id_remap_pkg;

    // Entry fields are sized for the widest supported configuration; unused upper bits stay zero.
    localparam int TAG_W_MAX = 32;
    localparam int CNT_W_MAX = 8;

    function automatic int cnt_width(input int max_txns);
        return $clog2(max_txns + 1);
    endfunction

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_MAX-1:0] tag;
        logic [CNT_W_MAX-1:0] cnt;
    } slot_entry_t;

endpackage

// File: rtl/axi_id_remap_lzc.sv
// Lowest-index free slot finder over the slot valid vector; empty_o means no slot is free.
module axi_id_remap_lzc #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input  logic [N-1:0]     valid_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             empty_o
);

    always_comb begin
        idx_o   = '0;
        empty_o = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid_i[i]) begin
                idx_o   = IDX_W'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_id_remap_table.sv
// Maps upstream AXI IDs onto a small pool of downstream IDs with per-slot outstanding counts.
// Define AXI_ID_REMAP_TABLE_STATS_EN to drive used_slots_o with a registered occupancy count.
module axi_id_remap_table
    import axi_id_remap_pkg::*;
#(
    parameter int AXI_ID_IN  = 8,
    parameter int AXI_ID_OUT = 4,
    parameter int ID_SLOT    = 16,
    parameter int MAX_TXNS   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_valid_i,
    output logic                         push_ready_o,
    input  logic [AXI_ID_IN-1:0]         push_id_i,
    output logic [AXI_ID_OUT-1:0]        push_out_id_o,
    input  logic                         pop_valid_i,
    input  logic [AXI_ID_OUT-1:0]        pop_out_id_i,
    output logic [AXI_ID_IN-1:0]         pop_in_id_o,
    output logic                         pop_err_o,
    output logic                         full_o,
    output logic [$clog2(ID_SLOT+1)-1:0] used_slots_o
);

    localparam int IDX_W  = (ID_SLOT > 1) ? $clog2(ID_SLOT) : 1;
    localparam int CNT_W  = cnt_width(MAX_TXNS);
    localparam int USED_W = $clog2(ID_SLOT + 1);
    localparam logic [CNT_W_MAX-1:0] CNT_MAX = CNT_W_MAX'(MAX_TXNS);
    localparam logic [CNT_W_MAX-1:0] CNT_ONE = CNT_W_MAX'(1);

    if (ID_SLOT > 2**AXI_ID_OUT) begin : g_chk_slots
        $error("ID_SLOT exceeds the downstream ID space");
    end
    if (AXI_ID_IN > TAG_W_MAX || CNT_W > CNT_W_MAX) begin : g_chk_widths
        $error("ID or counter width exceeds slot entry field width");
    end

    slot_entry_t            entry_q [ID_SLOT];
    slot_entry_t            entry_d [ID_SLOT];
    logic [ID_SLOT-1:0]     valid_vec;
    logic                   hit;
    logic [IDX_W-1:0]       hit_idx;
    logic [CNT_W_MAX-1:0]   hit_cnt;
    logic [IDX_W-1:0]       free_idx;
    logic                   none_free;
    logic [IDX_W-1:0]       grant_idx;
    logic                   push_fire;
    logic                   pop_ok;
    logic [IDX_W-1:0]       pop_idx;
    logic [AXI_ID_IN-1:0]   pop_tag;
    logic [ID_SLOT-1:0]     inc_vec;
    logic [ID_SLOT-1:0]     dec_vec;

    always_comb begin
        valid_vec = '0;
        hit       = 1'b0;
        hit_idx   = '0;
        hit_cnt   = '0;
        for (int i = 0; i < ID_SLOT; i++) begin
            valid_vec[i] = entry_q[i].valid;
            if (entry_q[i].valid && entry_q[i].tag == TAG_W_MAX'(push_id_i)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                hit_cnt = entry_q[i].cnt;
            end
        end
    end

    axi_id_remap_lzc #(
        .N     (ID_SLOT),
        .IDX_W (IDX_W)
    ) u_lzc (
        .valid_i (valid_vec),
        .idx_o   (free_idx),
        .empty_o (none_free)
    );

    // A saturated hit stalls rather than spilling the ID into a second slot, keeping AXI ordering.
    assign push_ready_o  = hit ? (hit_cnt < CNT_MAX) : !none_free;
    assign grant_idx     = hit ? hit_idx : free_idx;
    assign push_out_id_o = AXI_ID_OUT'(grant_idx);
    assign push_fire     = push_valid_i & push_ready_o;
    assign full_o        = none_free;

    always_comb begin
        pop_ok  = 1'b0;
        pop_idx = '0;
        pop_tag = '0;
        for (int i = 0; i < ID_SLOT; i++) begin
            if (pop_out_id_i == AXI_ID_OUT'(i) && entry_q[i].valid) begin
                pop_ok  = 1'b1;
                pop_idx = IDX_W'(i);
                pop_tag = entry_q[i].tag[AXI_ID_IN-1:0];
            end
        end
    end

    assign pop_in_id_o = pop_tag;
    assign pop_err_o   = rst_ni & pop_valid_i & ~pop_ok;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < ID_SLOT; i++) begin
            entry_d[i] = entry_q[i];
            inc_vec[i] = push_fire && (grant_idx == IDX_W'(i));
            dec_vec[i] = pop_valid_i && pop_ok && (pop_idx == IDX_W'(i));
            if (inc_vec[i] && !dec_vec[i]) begin
                if (!entry_q[i].valid) begin
                    entry_d[i].valid = 1'b1;
                    entry_d[i].tag   = TAG_W_MAX'(push_id_i);
                    entry_d[i].cnt   = CNT_ONE;
                end else begin
                    entry_d[i].cnt = entry_q[i].cnt + CNT_ONE;
                end
            end else if (dec_vec[i] && !inc_vec[i]) begin
                if (entry_q[i].cnt == CNT_ONE) begin
                    entry_d[i] = '0;
                end else begin
                    entry_d[i].cnt = entry_q[i].cnt - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ID_SLOT; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ID_SLOT; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

`ifdef AXI_ID_REMAP_TABLE_STATS_EN
    logic [USED_W-1:0] used_d;
    logic [USED_W-1:0] used_q;

    always_comb begin
        used_d = '0;
        for (int i = 0; i < ID_SLOT; i++) begin
            used_d = used_d + USED_W'(entry_d[i].valid);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            used_q <= '0;
        end else begin
            used_q <= used_d;
        end
    end

    assign used_slots_o = used_q;
`else
    assign used_slots_o = '0;
`endif

endmodule

// File: tb/tb_axi_id_remap_table.sv
// Self-checking bench for axi_id_remap_table: directed scenarios plus randomized traffic
// checked against a slot-table reference model.
module tb_axi_id_remap_table;

    localparam int IN_W   = 8;
    localparam int OUT_W  = 4;
    localparam int SLOTS  = 16;
    localparam int MAXT   = 4;
    localparam int USED_W = 5;
`ifdef AXI_ID_REMAP_TABLE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic              push_valid_i = 1'b0;
    logic              push_ready_o;
    logic [IN_W-1:0]   push_id_i = '0;
    logic [OUT_W-1:0]  push_out_id_o;
    logic              pop_valid_i = 1'b0;
    logic [OUT_W-1:0]  pop_out_id_i = '0;
    logic [IN_W-1:0]   pop_in_id_o;
    logic              pop_err_o;
    logic              full_o;
    logic [USED_W-1:0] used_slots_o;

    int checks = 0;
    int errors = 0;

    axi_id_remap_table #(
        .AXI_ID_IN  (IN_W),
        .AXI_ID_OUT (OUT_W),
        .ID_SLOT    (SLOTS),
        .MAX_TXNS   (MAXT)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push_valid_i  (push_valid_i),
        .push_ready_o  (push_ready_o),
        .push_id_i     (push_id_i),
        .push_out_id_o (push_out_id_o),
        .pop_valid_i   (pop_valid_i),
        .pop_out_id_i  (pop_out_id_i),
        .pop_in_id_o   (pop_in_id_o),
        .pop_err_o     (pop_err_o),
        .full_o        (full_o),
        .used_slots_o  (used_slots_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: which upstream ID owns each downstream ID and how many are in flight.
    bit m_valid [SLOTS];
    int m_tag   [SLOTS];
    int m_cnt   [SLOTS];

    function automatic int m_lookup(input int id);
        for (int i = 0; i < SLOTS; i++) if (m_valid[i] && m_tag[i] == id) return i;
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < SLOTS; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic int m_used();
        int n = 0;
        for (int i = 0; i < SLOTS; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic bit m_ready(input int id);
        int h = m_lookup(id);
        if (h >= 0) return m_cnt[h] < MAXT;
        return m_free() >= 0;
    endfunction

    function automatic int m_grant(input int id);
        int h = m_lookup(id);
        return (h >= 0) ? h : m_free();
    endfunction

    task automatic m_clear();
        for (int i = 0; i < SLOTS; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_cnt[i]   = 0;
        end
    endtask

    task automatic m_step(input bit pv, input int pid, input bit qv, input int qid);
        bit fire;
        bit pok;
        int g;
        fire = pv && m_ready(pid);
        g    = fire ? m_grant(pid) : -1;
        pok  = qv && qid < SLOTS && m_valid[qid];
        if (fire && pok && g == qid) return;
        if (fire) begin
            if (!m_valid[g]) begin
                m_valid[g] = 1'b1;
                m_tag[g]   = pid;
                m_cnt[g]   = 1;
            end else begin
                m_cnt[g]++;
            end
        end
        if (pok) begin
            m_cnt[qid]--;
            if (m_cnt[qid] == 0) m_valid[qid] = 1'b0;
        end
    endtask

    task automatic drive(input bit pv, input logic [IN_W-1:0] pid, input bit qv, input logic [OUT_W-1:0] qid);
        @(negedge clk_i);
        push_valid_i = pv;
        push_id_i    = pid;
        pop_valid_i  = qv;
        pop_out_id_i = qid;
        #4;
    endtask

    task automatic commit();
        @(posedge clk_i);
        if (rst_ni) m_step(push_valid_i, int'(push_id_i), pop_valid_i, int'(pop_out_id_i));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni       = 1'b0;
        push_valid_i = 1'b0;
        pop_valid_i  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_clear();
    endtask

    task automatic test_reset();
        #2;
        rst_ni       = 1'b0;
        push_valid_i = 1'b1;
        push_id_i    = 8'h5A;
        pop_valid_i  = 1'b1;
        pop_out_id_i = 4'd7;
        #1;
        checks++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", push_ready_o); end
        checks++; if (push_out_id_o !== 4'd0) begin errors++; $display("FAIL rst_out_id: got %0h want 0", push_out_id_o); end
        checks++; if (pop_in_id_o !== 8'h00) begin errors++; $display("FAIL rst_in_id: got %0h want 0", pop_in_id_o); end
        checks++; if (pop_err_o !== 1'b0) begin errors++; $display("FAIL rst_pop_err: got %b want 0", pop_err_o); end
        checks++; if (full_o !== 1'b0) begin errors++; $display("FAIL rst_full: got %b want 0", full_o); end
        checks++; if (used_slots_o !== 5'd0) begin errors++; $display("FAIL rst_used: got %0d want 0", used_slots_o); end
        @(negedge clk_i);
        push_valid_i = 1'b0;
        pop_valid_i  = 1'b0;
        rst_ni       = 1'b1;
        m_clear();
    endtask

    task automatic test_first_push();
        drive(1'b1, 8'hA5, 1'b0, 4'd0);
        checks++; if (push_ready_o !== 1'b1) begin errors++; $display("FAIL first_ready: got %b want 1", push_ready_o); end
        checks++; if (push_out_id_o !== 4'd0) begin errors++; $display("FAIL first_out_id: got %0h want 0", push_out_id_o); end
        commit();
        drive(1'b0, 8'h00, 1'b1, 4'd0);
        checks++; if (pop_err_o !== 1'b0) begin errors++; $display("FAIL first_pop_err: got %b want 0", pop_err_o); end
        checks++; if (pop_in_id_o !== 8'hA5) begin errors++; $display("FAIL first_in_id: got %0h want a5", pop_in_id_o); end
        commit();
        drive(1'b0, 8'h00, 1'b1, 4'd0);
        checks++; if (pop_err_o !== 1'b1) begin errors++; $display("FAIL first_cnt_was_1: pop_err got %b want 1", pop_err_o); end
        commit();
    endtask

    task automatic test_max_txns();
        for (int k = 0; k < MAXT; k++) begin
            drive(1'b1, 8'hA5, 1'b0, 4'd0);
            checks++; if (push_ready_o !== 1'b1 || push_out_id_o !== 4'd0) begin
                errors++; $display("FAIL max_push%0d: got ready %b id %0h want 1/0", k, push_ready_o, push_out_id_o);
            end
            commit();
        end
        drive(1'b1, 8'hA5, 1'b0, 4'd0);
        checks++; if (push_ready_o !== 1'b0) begin errors++; $display("FAIL max_fifth_ready: got %b want 0", push_ready_o); end
        commit();
        drive(1'b1, 8'h11, 1'b0, 4'd0);
        checks++; if (push_ready_o !== 1'b1 || push_out_id_o !== 4'd1) begin
            errors++; $display("FAIL max_other_id: got ready %b id %0h want 1/1", push_ready_o, push_out_id_o);
        end
        commit();
    endtask

    task automatic test_same_cycle();
        do_reset();
        repeat (2) begin drive(1'b1, 8'hA5, 1'b0, 4'd0); commit(); end
        drive(1'b1, 8'hA5, 1'b1, 4'd0);
        checks++; if (push_ready_o !== 1'b1 || pop_err_o !== 1'b0) begin
            errors++; $display("FAIL same_handshake: got ready %b err %b want 1/0", push_ready_o, pop_err_o);
        end
        commit();
        drive(1'b0, 8'h00, 1'b0, 4'd0);
        checks++; if (pop_in_id_o !== 8'hA5 || used_slots_o !== (STATS ? 5'd1 : 5'd0)) begin
            errors++; $display("FAIL same_valid: got in_id %0h used %0d", pop_in_id_o, used_slots_o);
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'h00, 1'b1, 4'd0);
            checks++; if (pop_err_o !== (k == 2)) begin
                errors++; $display("FAIL same_cnt_pop%0d: pop_err got %b want %b", k, pop_err_o, (k == 2));
            end
            commit();
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < SLOTS; i++) begin
            drive(1'b1, 8'(8'h20 + i), 1'b0, 4'd0);
            checks++; if (push_ready_o !== 1'b1 || push_out_id_o !== OUT_W'(i)) begin
                errors++; $display("FAIL fill%0d: got ready %b id %0h want 1/%0h", i, push_ready_o, push_out_id_o, i);
            end
            commit();
        end
        drive(1'b1, 8'h99, 1'b0, 4'd0);
        checks++; if (full_o !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", full_o); end
        checks++; if (used_slots_o !== (STATS ? 5'd16 : 5'd0)) begin errors++; $display("FAIL full_used: got %0d", used_slots_o); end
        checks++; if (push_ready_o !== 1'b0) begin errors++; $display("FAIL full_stall: got %b want 0", push_ready_o); end
        commit();
        drive(1'b1, 8'h99, 1'b1, 4'd3);
        checks++; if (push_ready_o !== 1'b0 || pop_err_o !== 1'b0) begin
            errors++; $display("FAIL full_prepop: got ready %b err %b want 0/0", push_ready_o, pop_err_o);
        end
        commit();
        drive(1'b1, 8'h99, 1'b0, 4'd0);
        checks++; if (push_ready_o !== 1'b1 || push_out_id_o !== 4'd3 || full_o !== 1'b0) begin
            errors++; $display("FAIL full_reuse3: got ready %b id %0h full %b want 1/3/0", push_ready_o, push_out_id_o, full_o);
        end
        commit();
    endtask

    task automatic test_pop_err();
        do_reset();
        drive(1'b1, 8'hA5, 1'b0, 4'd0);
        commit();
        drive(1'b0, 8'h00, 1'b1, 4'd7);
        checks++; if (pop_err_o !== 1'b1) begin errors++; $display("FAIL err_free_slot: got %b want 1", pop_err_o); end
        commit();
        drive(1'b1, 8'h33, 1'b0, 4'd0);
        checks++; if (pop_err_o !== 1'b0) begin errors++; $display("FAIL err_pulse_end: got %b want 0", pop_err_o); end
        checks++; if (push_ready_o !== 1'b1 || push_out_id_o !== 4'd1 || pop_in_id_o !== 8'hA5) begin
            errors++; $display("FAIL err_no_change: got ready %b id %0h in_id %0h", push_ready_o, push_out_id_o, pop_in_id_o);
        end
        checks++; if (used_slots_o !== (STATS ? 5'd1 : 5'd0)) begin errors++; $display("FAIL err_used: got %0d", used_slots_o); end
        commit();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin drive(1'b1, 8'(8'h40 + i), 1'b0, 4'd0); commit(); end
        drive(1'b1, 8'h77, 1'b1, 4'd2);
        checks++; if (used_slots_o !== (STATS ? 5'd5 : 5'd0) || push_out_id_o !== 4'd5) begin
            errors++; $display("FAIL mid_pre: got used %0d id %0h", used_slots_o, push_out_id_o);
        end
        rst_ni = 1'b0;
        #1;
        checks++; if (push_ready_o !== 1'b1 || push_out_id_o !== 4'd0) begin
            errors++; $display("FAIL mid_push: got ready %b id %0h want 1/0", push_ready_o, push_out_id_o);
        end
        checks++; if (pop_in_id_o !== 8'h00 || pop_err_o !== 1'b0 || full_o !== 1'b0 || used_slots_o !== 5'd0) begin
            errors++; $display("FAIL mid_outs: got in_id %0h err %b full %b used %0d", pop_in_id_o, pop_err_o, full_o, used_slots_o);
        end
        @(negedge clk_i);
        push_valid_i = 1'b0;
        pop_valid_i  = 1'b0;
        rst_ni       = 1'b1;
        m_clear();
        drive(1'b0, 8'h00, 1'b1, 4'd2);
        checks++; if (pop_err_o !== 1'b1) begin errors++; $display("FAIL mid_dropped: got %b want 1", pop_err_o); end
        commit();
    endtask

    task automatic test_random();
        bit               pv;
        bit               qv;
        logic [IN_W-1:0]  pid;
        logic [OUT_W-1:0] qid;
        int               g;
        bit               er;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            pv  = ($urandom_range(0, 9) < 6);
            qv  = ($urandom_range(0, 9) < 5);
            pid = 8'(($urandom_range(0, 19) * 11) + 3);
            qid = OUT_W'($urandom_range(0, SLOTS - 1));
            drive(pv, pid, qv, qid);
            checks++; if (push_ready_o !== m_ready(int'(pid))) begin
                errors++; $display("FAIL rnd_ready c%0d: got %b want %b", c, push_ready_o, m_ready(int'(pid)));
            end
            g = m_grant(int'(pid));
            if (m_ready(int'(pid))) begin
                checks++; if (push_out_id_o !== OUT_W'(g)) begin
                    errors++; $display("FAIL rnd_out_id c%0d: got %0h want %0h", c, push_out_id_o, g);
                end
            end
            er = qv && !m_valid[int'(qid)];
            checks++; if (pop_err_o !== er) begin
                errors++; $display("FAIL rnd_pop_err c%0d: got %b want %b", c, pop_err_o, er);
            end
            if (m_valid[int'(qid)]) begin
                checks++; if (pop_in_id_o !== IN_W'(m_tag[int'(qid)])) begin
                    errors++; $display("FAIL rnd_in_id c%0d: got %0h want %0h", c, pop_in_id_o, m_tag[int'(qid)]);
                end
            end
            checks++; if (full_o !== (m_used() == SLOTS)) begin
                errors++; $display("FAIL rnd_full c%0d: got %b used %0d", c, full_o, m_used());
            end
            checks++; if (used_slots_o !== (STATS ? USED_W'(m_used()) : 5'd0)) begin
                errors++; $display("FAIL rnd_used c%0d: got %0d want %0d", c, used_slots_o, m_used());
            end
            commit();
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_first_push();
        test_max_txns();
        test_same_cycle();
        test_full();
        test_pop_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
